// File: rtl/spike_event_encoder.sv
// Spike-to-ISI event encoder: timestamps accepted spikes, buffers the ISIs in a
// small FIFO drained over valid/ready. Define SPIKE_ENC_COUNT_EN for the event counter.
module spike_event_encoder #(
  parameter int TS_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spike_in,
  input  logic                clear,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [TS_WIDTH-1:0] ev_data,
  output logic                overflow,
  output logic [7:0]          ev_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [TS_WIDTH-1:0] isi_q, isi_d, isi_nxt;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         occ_q, occ_d;
  logic [TS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                overflow_q, overflow_d;
  logic                full, pop, push;

  assign ev_valid = (occ_q != {(PW+1){1'b0}});
  assign ev_data  = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a spike
  // when it is being drained; clear discards both spike and pop.
  always_comb begin
    full    = (occ_q == DEPTH_C);
    pop     = ev_valid && ev_ready && !clear;
    push    = spike_in && !clear && (!full || pop);
    isi_nxt = (isi_q == {TS_WIDTH{1'b1}}) ? isi_q : isi_q + TS_WIDTH'(1);

    mem_d      = mem_q;
    isi_d      = isi_nxt;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;

    if (clear) begin
      isi_d      = {TS_WIDTH{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      occ_d      = {(PW+1){1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = isi_nxt;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        isi_d           = {TS_WIDTH{1'b0}};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // Dropped spikes leave isi running so the next ISI spans from the last accepted event.
      if (spike_in && full && !pop) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + (PW+1)'(1);
        2'b01:   occ_d = occ_q - (PW+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers; storage resets to zero so ev_data is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_q      <= {TS_WIDTH{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      occ_q      <= {(PW+1){1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {TS_WIDTH{1'b0}};
      end
    end else begin
      isi_q      <= isi_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

`ifdef SPIKE_ENC_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (push && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Saturating accepted-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign ev_count = count_q;
`else
  assign ev_count = 8'd0;
`endif

endmodule
